// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: MM:SS BCD counter with RUN / PAUSE / ADJ modes.
// Optional feature macro: STOPWATCH_ROLLOVER_EN
//   defined   -> MIN_LIMIT:59 + tick_1hz in RUN rolls over to 00:00
//   undefined -> MIN_LIMIT:59 + tick_1hz in RUN holds at MIN_LIMIT:59
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pause_pulse       one-cycle pause/resume request
//   adj, sel          adjust-mode level, adjust field (0 = minutes, 1 = seconds)
//   tick_1hz          count enable (RUN only)
//   tick_2hz          adjust enable (ADJ only)
//   minutes_1/0,
//   seconds_1/0       registered BCD digits
//   running/adjusting registered state flags
module stopwatch_ctrl #(
  parameter int unsigned MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_pulse,
  input  logic       adj,
  input  logic       sel,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  output logic [3:0] minutes_1,
  output logic [3:0] minutes_0,
  output logic [3:0] seconds_1,
  output logic [3:0] seconds_0,
  output logic       running,
  output logic       adjusting
);

  localparam logic [3:0] LIM_1 = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_0 = 4'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;

  state_t state;
  logic   resume_paused;

  // BCD seconds increment, 59 -> 00
  function automatic logic [7:0] inc_sec(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd5 && u == 4'd9) return 8'h00;
    else if (u == 4'd9)         return {4'(t + 4'd1), 4'd0};
    else                        return {t, 4'(u + 4'd1)};
  endfunction

  // BCD minutes increment, MIN_LIMIT -> 00
  function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] u);
    if (t == LIM_1 && u == LIM_0) return 8'h00;
    else if (u == 4'd9)           return {4'(t + 4'd1), 4'd0};
    else                          return {t, 4'(u + 4'd1)};
  endfunction

  logic [7:0] sec_nxt;
  logic [7:0] min_nxt;
  logic       sec_at_59;
  logic       min_at_max;
  logic       rp_toggled;

  assign sec_nxt    = inc_sec(seconds_1, seconds_0);
  assign min_nxt    = inc_min(minutes_1, minutes_0);
  assign sec_at_59  = (seconds_1 == 4'd5) && (seconds_0 == 4'd9);
  assign min_at_max = (minutes_1 == LIM_1) && (minutes_0 == LIM_0);
  assign rp_toggled = resume_paused ^ pause_pulse;

  // State, flags and digits
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      resume_paused <= 1'b0;
      running       <= 1'b1;
      adjusting     <= 1'b0;
      minutes_1     <= 4'd0;
      minutes_0     <= 4'd0;
      seconds_1     <= 4'd0;
      seconds_0     <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (adj) begin
            // A simultaneous pause request counts as pausing first, so
            // leaving adjust should return to PAUSE.
            state         <= ADJ;
            resume_paused <= pause_pulse;
            running       <= 1'b0;
            adjusting     <= 1'b1;
          end else begin
            if (tick_1hz) begin
              if (sec_at_59) begin
                if (min_at_max) begin
`ifdef STOPWATCH_ROLLOVER_EN
                  minutes_1 <= 4'd0;
                  minutes_0 <= 4'd0;
                  seconds_1 <= 4'd0;
                  seconds_0 <= 4'd0;
`else
                  minutes_1 <= LIM_1;
                  minutes_0 <= LIM_0;
                  seconds_1 <= 4'd5;
                  seconds_0 <= 4'd9;
`endif
                end else begin
                  {minutes_1, minutes_0} <= min_nxt;
                  {seconds_1, seconds_0} <= 8'h00;
                end
              end else begin
                {seconds_1, seconds_0} <= sec_nxt;
              end
            end
            if (pause_pulse) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (adj) begin
            // A simultaneous pause request counts as resuming first.
            state         <= ADJ;
            resume_paused <= ~pause_pulse;
            adjusting     <= 1'b1;
          end else if (pause_pulse) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        ADJ: begin
          if (tick_2hz) begin
            if (sel) {seconds_1, seconds_0} <= sec_nxt;
            else     {minutes_1, minutes_0} <= min_nxt;
          end
          resume_paused <= rp_toggled;
          if (!adj) begin
            state     <= rp_toggled ? PAUSE : RUN;
            running   <= ~rp_toggled;
            adjusting <= 1'b0;
          end
        end
        default: begin
          state     <= RUN;
          running   <= 1'b1;
          adjusting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter MIN_LIMIT, default 59, giving the largest minutes value (legal range 1-99).
REQ-002 The block SHALL have port clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 The block SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port pause_pulse  input  1  debounced one-cycle pause/resume request.
REQ-005 The block SHALL have port adj  input  1  level; 1 = adjust mode requested.
REQ-006 The block SHALL have port sel  input  1  adjust field select; 0 = minutes, 1 = seconds.
REQ-007 The block SHALL have port tick_1hz  input  1  one-cycle count enable, 1 Hz.
REQ-008 The block SHALL have port tick_2hz  input  1  one-cycle adjust enable, 2 Hz.
REQ-009 The block SHALL have ports minutes_1, minutes_0, seconds_1, seconds_0  output  4 each  registered BCD digits to the display driver.
REQ-010 The block SHALL have port running  output  1  registered; 1 only in state RUN.
REQ-011 The block SHALL have port adjusting  output  1  registered; 1 only in state ADJ.

Function
REQ-012 The state machine SHALL have exactly three states: RUN, PAUSE and ADJ, plus a 1-bit resume_paused flag.
REQ-013 In RUN, tick_1hz SHALL increment the time: seconds 59 -> 00 with minutes +1, else seconds +1.
REQ-014 Digits SHALL stay valid BCD (0-9, tens of seconds 0-5) at all times; no binary values SHALL appear on the outputs.
REQ-015 Output latency SHALL be one cycle: digits SHALL reflect a tick on the clock edge that samples it.
REQ-016 In RUN, pause_pulse SHALL move the machine to PAUSE; in PAUSE, pause_pulse SHALL move it to RUN.
REQ-017 In PAUSE, tick_1hz SHALL be ignored and the digits SHALL hold.
REQ-018 From RUN or PAUSE, adj=1 SHALL move the machine to ADJ; resume_paused SHALL be set to 1 if leaving PAUSE and 0 if leaving RUN.
REQ-019 In ADJ, tick_1hz SHALL be ignored; tick_2hz SHALL increment only the selected field, with no carry between fields.
REQ-020 In ADJ, the seconds field SHALL wrap 59 -> 00 and the minutes field SHALL wrap MIN_LIMIT -> 00.
REQ-021 In ADJ, pause_pulse SHALL toggle resume_paused and the machine SHALL stay in ADJ.
REQ-022 In ADJ, adj=0 SHALL move the machine to PAUSE if resume_paused=1, else to RUN.
REQ-023 sel changes SHALL take effect on the next tick_2hz with no other side effect.
REQ-024 Simultaneous events SHALL be handled as follows:
- rst SHALL override everything.
- adj=1 arriving with tick_1hz in RUN SHALL enter ADJ and drop the tick.
- pause_pulse with tick_1hz in RUN SHALL count the tick and then enter PAUSE.
- pause_pulse with adj=1 SHALL enter ADJ with resume_paused set to 1 only if the current state is RUN.
REQ-025 Maximum value handling SHALL follow REQ-030/REQ-031 when time is MIN_LIMIT:59 and tick_1hz arrives in RUN.

Reset
REQ-026 On rst=1 at a clock edge, all four digits SHALL become 0 and the state SHALL become RUN.
REQ-027 On rst=1 at a clock edge, running SHALL be 1, adjusting SHALL be 0 and resume_paused SHALL be 0.
REQ-028 Reset asserted mid-adjust or mid-count SHALL discard any pending tick in the same cycle.
REQ-029 After reset deasserts, the first tick_1hz SHALL produce 00:01.

Configuration
REQ-030 With macro STOPWATCH_ROLLOVER_EN defined, MIN_LIMIT:59 plus tick_1hz in RUN SHALL give 00:00, and the machine SHALL stay in RUN.
REQ-031 Without STOPWATCH_ROLLOVER_EN, MIN_LIMIT:59 plus tick_1hz in RUN SHALL hold MIN_LIMIT:59 and remain in RUN; adjust wrap per REQ-020 SHALL be unaffected by the macro.

Verification
REQ-032 rst, then 75 tick_1hz pulses -> 01:15, running=1.
REQ-033 Pause test: at 00:10, pause_pulse, 5 tick_1hz, pause_pulse, 3 tick_1hz -> 00:13, running=0 during the pause window.
REQ-034 From 00:58, adj=1, sel=1, 3 tick_2hz -> 00:01 with minutes unchanged; sel=0, 2 tick_2hz -> 02:01; adj=0 -> RUN.
REQ-035 From PAUSE, adj=1, pause_pulse, adj=0 -> RUN; from RUN, adj=1, pause_pulse, adj=0 -> PAUSE.
REQ-036 At 59:59 (MIN_LIMIT=59), tick_1hz -> 00:00 with STOPWATCH_ROLLOVER_EN defined, 59:59 without it.
REQ-037 tick_1hz on the same edge as adj rising at 00:05 -> digits remain 00:05 and adjusting=1 next cycle.
